shift_rows_pipe: RTL
====================

// Module: shift_rows_pipe
// PURPOSE
//  Parametrised, pipelined Rijndael ShiftRows/InvShiftRows stage for the AES datapath.
//  Per beat, selects forward or inverse row rotation. Supports Nb = 4, 6 or 8 columns.
//  Uses a valid/ready elastic pipeline with a sideband tag carried alongside the data.
//  Sits between SubBytes/InvSubBytes and MixColumns/AddRoundKey in iterative and unrolled cores.
// PARAMETERS
//  NB      4  state columns (4, 6 or 8); data width = 32*NB
//  STAGES  1  pipeline register stages (1..4); sets latency
//  TAG_W   4  sideband tag width, passed through unchanged
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        async active-low reset
//  in_valid   in   1        input beat valid
//  in_ready   out  1        stage can accept a beat this cycle
//  in_data    in   32*NB    state; byte k at [8k+7:8k], row=k%4, col=k/4
//  in_inv     in   1        1 = InvShiftRows, 0 = ShiftRows
//  in_bypass  in   1        pass data unpermuted (honoured only with macro, see CONFIGURATION)
//  in_tag     in   TAG_W    sideband tag
//  out_valid  out  1        output beat valid
//  out_ready  in   1        downstream accepts
//  out_data   out  32*NB    permuted state
//  out_tag    out  TAG_W    tag of the beat on out_data
//  busy       out  1        OR of all stage valid bits
// BEHAVIOUR
//  - Row offsets: C0=0, C1=1, C2=(NB==8)?3:2, C3=(NB==8)?4:3.
//    fwd: out[r][c]=in[r][(c+Cr)%NB]; inv: out[r][c]=in[r][(c-Cr+NB)%NB].
//  - Permutation is combinational ahead of stage 0. Stages 1..STAGES-1 are pure registers.
//  - Transfer occurs when valid&&ready at a port. Stage s loads when it is empty or stage s+1 (or out) consumes.
//    in_ready = !v[0] | advance[0]. The ready chain is combinational, giving throughput of 1 beat/clk.
//  - Latency: beat accepted at edge N appears on out_valid after edge N+STAGES-1 (i.e. STAGES cycles).
//  - While out_valid && !out_ready, out_data/out_tag are held stable.
//  - Full pipe with out_ready=0: in_ready=0. Full with out_ready=1: simultaneous accept and emit, no bubble.
//  - Empty pipe: out_valid=0, busy=0, and in_ready=1 regardless of out_ready.
//  - in_inv, in_bypass and in_tag are sampled with the beat; mode may change on every beat.
//  - Reset (async assert, sync deassert expected from upstream): all valid bits, data and tag regs clear to 0.
//    out_valid=0, out_data=0, out_tag=0, busy=0, in_ready=1 after reset. Beats in flight are discarded.
//  - NB not in {4,6,8} or STAGES outside 1..4: elaboration-time $error in a generate block.
// CONFIGURATION
//  SHIFT_ROWS_BYPASS_EN defined: in_bypass=1 makes out_data=in_data, with the same latency and handshake.
//  Undefined: in_bypass is ignored (treated as 0) and the bypass mux is not built.
// TESTING
//  1 NB=4,STAGES=1, in_inv=0, in_data=0x0F0E0D0C0B0A09080706050403020100
//    -> one cycle later out_data=0x0B06010C07020D08030E09040F0A0500
//  2 same data, in_inv=1 -> out_data=0x0306090C0F0205080B0E0104070A0D00; in_tag=0x5 returned on out_tag
//  3 STAGES=3, 8 back-to-back beats, out_ready=1 -> out_valid after 3 clk, 8 consecutive beats, order/tags kept
//  4 STAGES=2, fill pipe with out_ready=0 -> in_ready=0 after 2 beats, out_data stable;
//    release out_ready -> no beat lost or duplicated
//  5 NB=8: fwd then inv with tag=0xA (two chained instances) -> round trip equals input;
//    mid-stream rst_n=0 -> out_valid=0, busy=0 immediately
//  6 macro defined, in_bypass=1, in_inv=1 -> out_data==in_data; macro undefined -> same stimulus gives inverse result

Source files
------------

// File: rtl/shift_rows_pipe.sv
// Pipelined AES ShiftRows/InvShiftRows for NB = 4/6/8 columns; SHIFT_ROWS_BYPASS_EN adds an unpermuted path.
// Latency: STAGES cycles from input handshake to out_valid; full throughput of one beat per clock.
// Backpressure: combinational ready chain; a stalled output holds data/tag and stalls every full stage behind it.
module shift_rows_pipe #(
  parameter int NB     = 4,
  parameter int STAGES = 1,
  parameter int TAG_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [32*NB-1:0]   in_data,
  input  logic               in_inv,
  input  logic               in_bypass,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [32*NB-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);

  localparam int W = 32 * NB;

  // Rijndael row rotation amounts; NB=8 uses the wider spread for rows 2 and 3.
  function automatic int row_off(input int r);
    case (r)
      0:       return 0;
      1:       return 1;
      2:       return (NB == 8) ? 3 : 2;
      default: return (NB == 8) ? 4 : 3;
    endcase
  endfunction

  generate
    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("shift_rows_pipe: STAGES must be 1..4");
    end
  endgenerate

  logic [W-1:0] w_perm;
  logic [W-1:0] w_stage_in;

  for (genvar gc = 0; gc < NB; gc++) begin : g_col
    for (genvar gr = 0; gr < 4; gr++) begin : g_row
      localparam int SRC_F = 4 * ((gc + row_off(gr)) % NB) + gr;
      localparam int SRC_I = 4 * ((gc - row_off(gr) + NB) % NB) + gr;
      assign w_perm[8*(4*gc+gr) +: 8] = in_inv ? in_data[8*SRC_I +: 8] : in_data[8*SRC_F +: 8];
    end
  end

`ifdef SHIFT_ROWS_BYPASS_EN
  assign w_stage_in = in_bypass ? in_data : w_perm;
`else
  logic w_unused_bypass;
  assign w_unused_bypass = in_bypass;
  assign w_stage_in      = w_perm;
`endif

  logic [STAGES-1:0] r_vld;
  logic [W-1:0]      r_dat [STAGES];
  logic [TAG_W-1:0]  r_tag [STAGES];

  logic [STAGES:0]   w_rdy;
  logic [STAGES-1:0] w_src_vld;
  logic [W-1:0]      w_src_dat [STAGES];
  logic [TAG_W-1:0]  w_src_tag [STAGES];

  // A stage may load when it is empty or whatever sits downstream of it moves on this cycle.
  assign w_rdy[STAGES] = out_ready;

  for (genvar gs = 0; gs < STAGES; gs++) begin : g_stage
    assign w_rdy[gs] = ~r_vld[gs] | w_rdy[gs+1];
    if (gs == 0) begin : g_head
      assign w_src_vld[gs] = in_valid;
      assign w_src_dat[gs] = w_stage_in;
      assign w_src_tag[gs] = in_tag;
    end else begin : g_body
      assign w_src_vld[gs] = r_vld[gs-1];
      assign w_src_dat[gs] = r_dat[gs-1];
      assign w_src_tag[gs] = r_tag[gs-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int s = 0; s < STAGES; s++) begin
        r_dat[s] <= '0;
        r_tag[s] <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (w_rdy[s]) begin
          r_vld[s] <= w_src_vld[s];
          if (w_src_vld[s]) begin
            r_dat[s] <= w_src_dat[s];
            r_tag[s] <= w_src_tag[s];
          end
        end
      end
    end
  end

  assign in_ready  = w_rdy[0];
  assign out_valid = r_vld[STAGES-1];
  assign out_data  = r_dat[STAGES-1];
  assign out_tag   = r_tag[STAGES-1];
  assign busy      = |r_vld;

endmodule
